// File: rtl/demux3_buf.sv
// demux3_buf: routes one upstream word to one of three channels,
// each behind a one-entry buffer; invalid selects are dropped and counted.
module demux3_buf #(
    parameter int LARGURA = 3
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [LARGURA-1:0] Dado,
    input  logic [1:0]         Sinal,
    input  logic               Valido_in,
    output logic               Pronto_in,
    output logic [LARGURA-1:0] Saida0,
    output logic [LARGURA-1:0] Saida1,
    output logic [LARGURA-1:0] Saida2,
    output logic               Valido0,
    output logic               Valido1,
    output logic               Valido2,
    input  logic               Pronto0,
    input  logic               Pronto1,
    input  logic               Pronto2,
    output logic [3:0]         ContErros
);

    logic [LARGURA-1:0] dado_q [3];
    logic [2:0]         cheio;
    logic [2:0]         pronto;
    logic [2:0]         carga;
    logic               aceito;
    logic               invalido;

    assign pronto = {Pronto2, Pronto1, Pronto0};

    // Upstream ready: selected buffer empty or draining this cycle
    always_comb begin
        Pronto_in = 1'b1;
        unique case (Sinal)
            2'b00:   Pronto_in = !cheio[0] || pronto[0];
            2'b01:   Pronto_in = !cheio[1] || pronto[1];
            2'b10:   Pronto_in = !cheio[2] || pronto[2];
            default: Pronto_in = 1'b1;
        endcase
    end

    assign aceito   = Valido_in && Pronto_in;
    assign invalido = aceito && (Sinal == 2'b11);

    // One-hot load strobe for the addressed channel
    always_comb begin
        carga = '0;
        unique case (Sinal)
            2'b00:   carga = {2'b00, aceito};
            2'b01:   carga = {1'b0, aceito, 1'b0};
            2'b10:   carga = {aceito, 2'b00};
            default: carga = '0;
        endcase
    end

    // Channel buffers: load wins over drain, data held when emptied
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cheio <= '0;
            for (int k = 0; k < 3; k++) begin
                dado_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (carga[k]) begin
                    dado_q[k] <= Dado;
                    cheio[k]  <= 1'b1;
                end else if (cheio[k] && pronto[k]) begin
                    cheio[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating counter of discarded invalid-select words
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ContErros <= '0;
        end else if (invalido && ContErros != 4'd15) begin
            ContErros <= ContErros + 4'd1;
        end
    end

    assign Saida0  = dado_q[0];
    assign Saida1  = dado_q[1];
    assign Saida2  = dado_q[2];
    assign Valido0 = cheio[0];
    assign Valido1 = cheio[1];
    assign Valido2 = cheio[2];

endmodule

// File: doc/demux3_buf.md
DEMUX3_BUF -- requirements
Module: demux3_buf

Interface
REQ-001 SHALL have parameter LARGURA, default 3, data width of every data port.
REQ-002 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Dado  input  LARGURA  upstream data word.
REQ-005 SHALL have port Sinal  input  2  destination select (00 -> ch0, 01 -> ch1, 10 -> ch2, 11 -> invalid).
REQ-006 SHALL have port Valido_in  input  1  upstream word valid.
REQ-007 SHALL have port Pronto_in  output  1  block can accept the word this cycle.
REQ-008 SHALL have ports Saida0, Saida1, Saida2  output  LARGURA  registered channel data.
REQ-009 SHALL have ports Valido0, Valido1, Valido2  output  1  channel holds a word.
REQ-010 SHALL have ports Pronto0, Pronto1, Pronto2  input  1  downstream consumer ready.
REQ-011 SHALL have port ContErros  output  4  saturating count of discarded invalid-select words.

Function
REQ-012 SHALL treat an upstream transfer as accepted on a rising Clock edge with Valido_in=1 and Pronto_in=1.
REQ-013 SHALL treat a channel-k transfer as completed on a rising Clock edge with Validok=1 and Prontok=1.
REQ-014 SHALL give each channel a one-entry buffer with two states: VAZIO (Validok=0) and CHEIO (Validok=1).
REQ-015 SHALL assert Pronto_in combinationally when Sinal=11, or when the selected channel is VAZIO, or when it is CHEIO with its Prontok=1 (same-cycle drain and refill).
REQ-016 SHALL keep Pronto_in independent of Valido_in.
REQ-017 SHALL, on an accepted word with Sinal=k (k in 0..2), load Dado into Saidak and set channel k to CHEIO on the same edge; latency Dado-to-Saidak is one cycle.
REQ-018 SHALL, on a completed channel transfer with no simultaneous load into that channel, move the channel to VAZIO; Saidak SHALL hold its last value.
REQ-019 SHALL, on a simultaneous drain and load of the same channel, stay CHEIO with Saidak taking the new Dado.
REQ-020 SHALL keep Saidak and Validok stable while CHEIO and Prontok=0.
REQ-021 SHALL let the three channels drain independently and concurrently; a stalled channel SHALL NOT block upstream words addressed to other channels.
REQ-022 SHALL, on an accepted word with Sinal=11, discard the word, leave all channels unchanged, and increment ContErros by 1.
REQ-023 SHALL saturate ContErros at 15; further invalid words are discarded without wrap.
REQ-024 SHALL ignore Dado and Sinal on cycles with Valido_in=0; no state change.
REQ-025 SHALL preserve word order per channel; no ordering guarantee across channels.

Reset
REQ-026 SHALL, while Resetn=0, immediately force Valido0..2=0, Saida0..2=0, ContErros=0, all channels VAZIO, without waiting for Clock.
REQ-027 SHALL, on a Resetn assertion mid-transfer, drop any buffered words; no partial word SHALL appear after release.
REQ-028 SHALL accept words from the first rising Clock edge after Resetn returns to 1; Pronto_in SHALL be 1 for valid selects then.

Verification
REQ-029 Basic route: Dado=3'b101, Sinal=01, Valido_in=1, Pronto1=1 for one cycle -> next cycle Saida1=101, Valido1=1, Valido0=Valido2=0; following edge Valido1=0.
REQ-030 Backpressure: Pronto2=0, send 3'b011 then 3'b110 to Sinal=10 -> first accepted, Pronto_in=0 for second; Saida2 holds 011; raise Pronto2 -> 011 consumed, 110 accepted same edge, Saida2=110.
REQ-031 Independence: ch0 CHEIO with Pronto0=0; send 3'b111 with Sinal=00 then Sinal=10 -> ch0 word stalls (Pronto_in=0), re-presented with Sinal=10 it is accepted, Saida2=111, Valido2=1.
REQ-032 Invalid select: 17 accepted words with Sinal=11 -> ContErros=15, all Valido=0, Pronto_in=1 throughout.
REQ-033 Async reset: ch0 and ch1 CHEIO, ContErros=3, drop Resetn between Clock edges -> all outputs 0 immediately; after release first word to Sinal=00 appears next cycle.
REQ-034 Full throughput: Pronto1=1, back-to-back words 0..7 to Sinal=01 -> Pronto_in=1 every cycle, Saida1 shows 0..7 on consecutive cycles.
